svm_rom_sequencer: RTL
======================

# svm_rom_sequencer

Control-side initiator for the SVM ROM memory wrapper. Accepts one classification request, then walks the four ROM read phases in fixed order: voltage support rows, voltage alphas, accelerometer support rows, accelerometer alphas. For each read it drives the phase flags and the `midx`/`comp_sidx` indices, and it returns a registered valid/tag stream aligned to the ROM's 1-cycle read data. It sits between the SVM top-level controller and the memory wrapper, and it is the only driver of the wrapper's address-select inputs.

## Interface

Parameters:
- `LOG_SUP_WIDTH`, default 8: width of `comp_sidx`.
- `LOG_MIDX`, default 8: width of `midx`.
- `V_MIDX_COUNT`, default 64: support-row reads in V_MM1. Range 1..2^LOG_MIDX.
- `V_SUP_COUNT`, default 64: alpha reads in V_MM2. Range 1..2^LOG_SUP_WIDTH.
- `A_MIDX_COUNT`, default 64: support-row reads in A_MM1. Range 1..2^LOG_MIDX.
- `A_SUP_COUNT`, default 64: alpha reads in A_MM2. Range 1..2^LOG_SUP_WIDTH.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: request to start a classification.
- `in_ready`, output, 1: high only in IDLE.
- `computing_v_matmul1`, output, 1: phase flag, high in V_MM1.
- `computing_v_matmul2`, output, 1: phase flag, high in V_MM2.
- `computing_a_matmul1`, output, 1: phase flag, high in A_MM1.
- `computing_a_matmul2`, output, 1: phase flag, high in A_MM2.
- `midx`, output, LOG_MIDX: support-row index.
- `comp_sidx`, output, LOG_SUP_WIDTH: alpha index.
- `rd_valid`, output, 1: ROM data on the wrapper outputs is valid this cycle.
- `rd_phase`, output, 2: phase of the returned data. 0 = V_MM1, 1 = V_MM2, 2 = A_MM1, 3 = A_MM2.
- `rd_idx`, output, max(LOG_MIDX, LOG_SUP_WIDTH): index of the returned data, zero-extended.
- `rd_last`, output, 1: the returned data is the last read of its phase.
- `done`, output, 1: single-cycle pulse when the final read returns.

## Operation

- States are IDLE, V_MM1, V_MM2, A_MM1, A_MM2 and DRAIN. The four phase flags are registered state decodes. They are one-hot in the MM states and all zero in IDLE and DRAIN.
- IDLE
  - `in_ready` = 1.
  - When `in_valid` is high, go to V_MM1 with `midx` = 0.
- V_MM1
  - `midx` increments by 1 each cycle.
  - In the cycle where `midx` == V_MIDX_COUNT-1: clear `midx` to 0, go to V_MM2 with `comp_sidx` = 0.
- V_MM2
  - `comp_sidx` increments by 1 each cycle.
  - At V_SUP_COUNT-1: clear `comp_sidx`, go to A_MM1.
- A_MM1 and A_MM2 behave the same way, using A_MIDX_COUNT and A_SUP_COUNT. A_MM2 exits to DRAIN.
- DRAIN: one cycle, then IDLE.
- Index hold rules:
  - `midx` is 0 whenever the state is not V_MM1 or A_MM1.
  - `comp_sidx` is 0 whenever the state is not V_MM2 or A_MM2.
  - The wrapper therefore reads address 0 while the sequencer is idle.
- Return tag path, 1-stage register that matches the ROM read latency:
  - `rd_valid` is the registered OR of the four phase flags.
  - `rd_phase` is the registered phase encoding.
  - `rd_idx` is the registered active index.
  - `rd_last` is the registered terminal-count condition.
- `done` = `rd_valid` & `rd_last` & (`rd_phase` == 3). It is asserted during DRAIN.
- Boundary conditions:
  - A count of 1 gives a single-cycle phase: index 0, with `rd_last` set on that read.
  - A count equal to 2^width wraps to 0 on the terminal read. This is legal because the terminal compare is against COUNT-1.
  - `in_valid` outside IDLE is ignored. It is not queued.
  - There is no abort. Only `rst` terminates an operation.
  - Reset mid-operation returns to IDLE immediately. Any in-flight `rd_valid` is dropped and `done` is not pulsed.

## Timing

- Reset values:
  - state = IDLE, so `in_ready` = 1.
  - All phase flags, `midx`, `comp_sidx`, `rd_valid`, `rd_phase`, `rd_idx`, `rd_last` and `done` are 0.
- Request accepted at clock edge E0:
  - V_MM1 occupies cycles 1..V, where V = V_MIDX_COUNT.
  - The other phases follow back to back with no bubbles.
  - Let T = V_MIDX_COUNT + V_SUP_COUNT + A_MIDX_COUNT + A_SUP_COUNT.
  - DRAIN and `done` occur in cycle T+1.
  - IDLE and `in_ready` return in cycle T+2.
- The data for the address issued in cycle k is returned with `rd_valid`/tag in cycle k+1.
- `rd_valid` is continuous from cycle 2 through cycle T+1, including across phase boundaries.
- With `in_valid` held high, the next accept happens at the end of cycle T+2, so accepts are T+2 cycles apart.

## Test plan

- Reset, then idle:
  - Check `in_ready` = 1, all flags 0, indices 0, `rd_valid` = 0, `done` = 0.
- Counts 4/3/2/5, single request:
  - Flags are one-hot across cycles 1–4, 5–7, 8–9 and 10–14.
  - `midx` runs 0,1,2,3 then 0,1.
  - `comp_sidx` runs 0,1,2 then 0..4.
  - `rd_valid` runs cycles 2–15.
  - `rd_last` at cycles 5, 8, 10 and 15.
  - `done` only at cycle 15; `in_ready` back at cycle 16.
- All counts = 1:
  - Phases at cycles 1–4, `rd_last` on every return, `done` at cycle 5.
- Counts 256 with width 8:
  - `midx` reaches 255 and then reads 0 in the next phase.
  - `rd_last` tag carries `rd_idx` = 255.
- `in_valid` held high:
  - Pulsed mid-operation: no effect.
  - Held continuously: accepts are exactly T+2 cycles apart, and the second run's tag stream is identical to the first.
- Assert `rst` during A_MM1 at count 4/3/2/5:
  - Immediately: `rd_valid` = 0, flags = 0, `in_ready` = 1.
  - No `done` is pulsed.
  - A new request runs the full sequence cleanly.

Source files
------------

// File: rtl/svm_rom_sequencer.sv
// rtl/svm_rom_sequencer.sv - SVM ROM read sequencer: walks V/A support-row and alpha reads, returns aligned tags
//
// Purpose:
//   Accepts one classification request and issues the four ROM read phases
//   back to back (V_MM1, V_MM2, A_MM1, A_MM2), then a one-cycle DRAIN.
//   A one-stage tag register tracks the ROM's single-cycle read latency.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - start request; ready only while idle
//   computing_*          - registered one-hot phase flags to the ROM wrapper
//   midx, comp_sidx      - support-row / alpha read indices (0 when not in use)
//   rd_valid, rd_phase,
//   rd_idx, rd_last      - tag of the data the ROM presents this cycle
//   done                 - pulse when the final A_MM2 read returns

module svm_rom_sequencer #(
   parameter  int LOG_SUP_WIDTH = 8,
   parameter  int LOG_MIDX      = 8,
   parameter  int V_MIDX_COUNT  = 64,
   parameter  int V_SUP_COUNT   = 64,
   parameter  int A_MIDX_COUNT  = 64,
   parameter  int A_SUP_COUNT   = 64,
   localparam int IDX_W = (LOG_MIDX > LOG_SUP_WIDTH) ? LOG_MIDX : LOG_SUP_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     computing_v_matmul1,
   output logic                     computing_v_matmul2,
   output logic                     computing_a_matmul1,
   output logic                     computing_a_matmul2,
   output logic [LOG_MIDX-1:0]      midx,
   output logic [LOG_SUP_WIDTH-1:0] comp_sidx,
   output logic                     rd_valid,
   output logic [1:0]               rd_phase,
   output logic [IDX_W-1:0]         rd_idx,
   output logic                     rd_last,
   output logic                     done
);

   typedef enum logic [2:0] {
      S_IDLE, S_V_MM1, S_V_MM2, S_A_MM1, S_A_MM2, S_DRAIN
   } state_t;

   // Terminal indices; a count of 2^width truncates to all-ones, so the
   // index wraps to 0 exactly on the terminal read.
   localparam logic [LOG_MIDX-1:0]      V_MIDX_LAST = LOG_MIDX'(V_MIDX_COUNT - 1);
   localparam logic [LOG_SUP_WIDTH-1:0] V_SUP_LAST  = LOG_SUP_WIDTH'(V_SUP_COUNT - 1);
   localparam logic [LOG_MIDX-1:0]      A_MIDX_LAST = LOG_MIDX'(A_MIDX_COUNT - 1);
   localparam logic [LOG_SUP_WIDTH-1:0] A_SUP_LAST  = LOG_SUP_WIDTH'(A_SUP_COUNT - 1);

   state_t                   r_state;
   logic [3:0]               r_flags;     // {a_mm2, a_mm1, v_mm2, v_mm1}
   logic                     r_in_ready;
   logic [LOG_MIDX-1:0]      r_midx;
   logic [LOG_SUP_WIDTH-1:0] r_sidx;
   logic                     r_rd_valid;
   logic [1:0]               r_rd_phase;
   logic [IDX_W-1:0]         r_rd_idx;
   logic                     r_rd_last;

   logic                     w_last;
   logic [1:0]               w_phase;
   logic [IDX_W-1:0]         w_idx;

   // Decode of the read being issued this cycle; feeds both the state
   // transitions and the tag register.
   always_comb begin
      w_last  = 1'b0;
      w_phase = 2'd0;
      w_idx   = '0;
      case (r_state)
         S_V_MM1: begin w_last = (r_midx == V_MIDX_LAST); w_phase = 2'd0; w_idx = IDX_W'(r_midx); end
         S_V_MM2: begin w_last = (r_sidx == V_SUP_LAST);  w_phase = 2'd1; w_idx = IDX_W'(r_sidx); end
         S_A_MM1: begin w_last = (r_midx == A_MIDX_LAST); w_phase = 2'd2; w_idx = IDX_W'(r_midx); end
         S_A_MM2: begin w_last = (r_sidx == A_SUP_LAST);  w_phase = 2'd3; w_idx = IDX_W'(r_sidx); end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_flags    <= 4'b0000;
         r_in_ready <= 1'b1;
         r_midx     <= '0;
         r_sidx     <= '0;
         r_rd_valid <= 1'b0;
         r_rd_phase <= 2'd0;
         r_rd_idx   <= '0;
         r_rd_last  <= 1'b0;
      end else begin
         r_rd_valid <= |r_flags;
         r_rd_phase <= w_phase;
         r_rd_idx   <= w_idx;
         r_rd_last  <= w_last;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_state    <= S_V_MM1;
                  r_flags    <= 4'b0001;
                  r_in_ready <= 1'b0;
                  r_midx     <= '0;
               end
            end
            S_V_MM1: begin
               if (w_last) begin
                  r_state <= S_V_MM2;
                  r_flags <= 4'b0010;
                  r_midx  <= '0;
                  r_sidx  <= '0;
               end else begin
                  r_midx <= r_midx + 1'b1;
               end
            end
            S_V_MM2: begin
               if (w_last) begin
                  r_state <= S_A_MM1;
                  r_flags <= 4'b0100;
                  r_sidx  <= '0;
                  r_midx  <= '0;
               end else begin
                  r_sidx <= r_sidx + 1'b1;
               end
            end
            S_A_MM1: begin
               if (w_last) begin
                  r_state <= S_A_MM2;
                  r_flags <= 4'b1000;
                  r_midx  <= '0;
                  r_sidx  <= '0;
               end else begin
                  r_midx <= r_midx + 1'b1;
               end
            end
            S_A_MM2: begin
               if (w_last) begin
                  r_state <= S_DRAIN;
                  r_flags <= 4'b0000;
                  r_sidx  <= '0;
               end else begin
                  r_sidx <= r_sidx + 1'b1;
               end
            end
            S_DRAIN: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
            end
            default: begin
               r_state    <= S_IDLE;
               r_flags    <= 4'b0000;
               r_in_ready <= 1'b1;
               r_midx     <= '0;
               r_sidx     <= '0;
            end
         endcase
      end
   end

   assign in_ready            = r_in_ready;
   assign computing_v_matmul1 = r_flags[0];
   assign computing_v_matmul2 = r_flags[1];
   assign computing_a_matmul1 = r_flags[2];
   assign computing_a_matmul2 = r_flags[3];
   assign midx                = r_midx;
   assign comp_sidx           = r_sidx;
   assign rd_valid            = r_rd_valid;
   assign rd_phase            = r_rd_phase;
   assign rd_idx              = r_rd_idx;
   assign rd_last             = r_rd_last;
   // The final tag is the only one with phase 3 and last set, so done lands in DRAIN.
   assign done                = r_rd_valid & r_rd_last & (r_rd_phase == 2'd3);

endmodule
